// File: rtl/emb_frame_scheduler.sv
// emb_frame_scheduler: builds one output frame from embedded and video streams.
// Front embedded lines, video lines, tail embedded lines; owns tuser/tlast timing.
module emb_frame_scheduler #(
  parameter int DATA_W = 16,
  parameter int H_SIZE = 1920,
  parameter int V_SIZE = 1280,
  parameter int FRONT_LINE = 2,
  parameter int TAIL_LINE = 4,
  parameter logic [5:0] EMB_TYPE = 6'h12,
  parameter logic [5:0] RAW12_TYPE = 6'h2C
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              enable,
  input  logic              s_emb_tvalid,
  output logic              s_emb_tready,
  input  logic [DATA_W-1:0] s_emb_tdata,
  input  logic              s_vid_tvalid,
  output logic              s_vid_tready,
  input  logic [DATA_W-1:0] s_vid_tdata,
  input  logic              s_vid_tuser,
  input  logic              s_vid_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [95:0]       m_axis_tuser,
  output logic              m_axis_tlast,
  output logic [31:0]       frame_cnt,
  output logic              frame_done,
  output logic              len_err,
  output logic              sof_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_FRONT, S_VIDEO,
    S_PAD, S_DROP, S_TAIL
  } state_t;

  localparam int LM0 = (V_SIZE > FRONT_LINE) ? V_SIZE : FRONT_LINE;
  localparam int LMAX = (LM0 > TAIL_LINE) ? LM0 : TAIL_LINE;
  localparam int CW = $clog2(H_SIZE);
  localparam int LW = $clog2(LMAX + 1);

  localparam logic [CW-1:0] COL_LAST = CW'(H_SIZE - 1);
  localparam logic [LW-1:0] FR_LAST = LW'(FRONT_LINE - 1);
  localparam logic [LW-1:0] VID_LAST = LW'(V_SIZE - 1);
  localparam logic [LW-1:0] TL_LAST = LW'(TAIL_LINE - 1);
  localparam state_t FIRST_ST = (FRONT_LINE > 0) ? S_FRONT : S_VIDEO;
  localparam state_t AFTER_VID = (TAIL_LINE > 0) ? S_TAIL : S_IDLE;
  localparam bit HAS_TAIL = (TAIL_LINE > 0);

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [LW-1:0]   line_q, line_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            len_q, len_d;
  logic            sof_q, sof_d;

  logic            col_last;
  logic            line_end;
  logic            frame_end;
  logic            act;
  logic            sof_bit;
  logic [5:0]      typ;

  assign col_last = (col_q == COL_LAST);

  // Next-state: region sequencing, column/line counting, error flags.
  always_comb begin
    state_d = state_q;
    col_d = col_q;
    line_d = line_q;
    cnt_d = cnt_q;
    done_d = 1'b0;
    len_d = len_q;
    sof_d = sof_q;
    line_end = 1'b0;
    frame_end = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_SYNC;
      end
      S_SYNC: begin
        if (s_vid_tvalid && s_vid_tuser) begin
          state_d = FIRST_ST;
          col_d = '0;
          line_d = '0;
        end
      end
      S_FRONT, S_TAIL: begin
        if (s_emb_tvalid && m_axis_tready) begin
          if (col_last) begin
            col_d = '0;
            line_end = 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_VIDEO: begin
        if (s_vid_tvalid && m_axis_tready) begin
          if (s_vid_tuser && !(line_q == '0 && col_q == '0))
            sof_d = 1'b1;
          if (col_last) begin
            col_d = '0;
            if (s_vid_tlast) begin
              line_end = 1'b1;
            end else begin
              len_d = 1'b1;
              state_d = S_DROP;
            end
          end else begin
            col_d = col_q + 1'b1;
            if (s_vid_tlast) begin
              len_d = 1'b1;
              state_d = S_PAD;
            end
          end
        end
      end
      S_PAD: begin
        if (m_axis_tready) begin
          if (col_last) begin
            col_d = '0;
            line_end = 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_DROP: begin
        if (s_vid_tvalid) begin
          if (s_vid_tuser) sof_d = 1'b1;
          if (s_vid_tlast) line_end = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (line_end) begin
      line_d = line_q + 1'b1;
      unique case (state_q)
        S_FRONT: begin
          if (line_q == FR_LAST) begin
            line_d = '0;
            state_d = S_VIDEO;
          end
        end
        S_TAIL: begin
          if (line_q == TL_LAST) begin
            line_d = '0;
            frame_end = 1'b1;
          end
        end
        default: begin
          state_d = S_VIDEO;
          if (line_q == VID_LAST) begin
            line_d = '0;
            state_d = AFTER_VID;
            frame_end = !HAS_TAIL;
          end
        end
      endcase
    end

    if (frame_end) begin
      cnt_d = cnt_q + 32'd1;
      done_d = 1'b1;
      state_d = enable ? S_SYNC : S_IDLE;
    end
  end

  // State, counters and sticky flags; synchronous reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= S_IDLE;
      col_q <= '0;
      line_q <= '0;
      cnt_q <= '0;
      done_q <= 1'b0;
      len_q <= 1'b0;
      sof_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      line_q <= line_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
      len_q <= len_d;
      sof_q <= sof_d;
    end
  end

  // Zero-latency output mux selected by the current region.
  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata = '0;
    s_emb_tready = 1'b0;
    s_vid_tready = 1'b0;
    typ = '0;
    act = 1'b0;
    unique case (state_q)
      S_SYNC: begin
        s_vid_tready = !(s_vid_tvalid && s_vid_tuser);
      end
      S_FRONT, S_TAIL: begin
        m_axis_tvalid = s_emb_tvalid;
        s_emb_tready = m_axis_tready;
        m_axis_tdata = s_emb_tdata;
        typ = EMB_TYPE;
        act = 1'b1;
      end
      S_VIDEO: begin
        m_axis_tvalid = s_vid_tvalid;
        s_vid_tready = m_axis_tready;
        m_axis_tdata = s_vid_tdata;
        typ = RAW12_TYPE;
        act = 1'b1;
      end
      S_PAD: begin
        m_axis_tvalid = 1'b1;
        typ = RAW12_TYPE;
        act = 1'b1;
      end
      S_DROP: begin
        s_vid_tready = 1'b1;
      end
      default: begin
        m_axis_tvalid = 1'b0;
      end
    endcase
  end

  assign sof_bit = act && (state_q == FIRST_ST)
                 && (line_q == '0) && (col_q == '0);
  assign m_axis_tlast = act && col_last;
  assign m_axis_tuser = act ? {32'd0, 16'(H_SIZE), 41'd0, typ, sof_bit}
                            : 96'd0;

  assign frame_cnt = cnt_q;
  assign frame_done = done_q;
  assign len_err = len_q;
  assign sof_err = sof_q;

endmodule

// File: tb/tb_emb_frame_scheduler.sv
// tb_emb_frame_scheduler: scoreboard bench for emb_frame_scheduler.
// Expected output beats are queued as source frames are built.
module tb_emb_frame_scheduler;
  localparam int DW = 16;
  localparam int H = 8;
  localparam int V = 4;
  localparam int FL = 2;
  localparam int TL = 1;
  localparam logic [5:0] ET = 6'h12;
  localparam logic [5:0] VT = 6'h2C;
  localparam int LIM = 3000;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  logic enable = 1'b0;
  logic s_emb_tvalid = 1'b0, s_emb_tready;
  logic [DW-1:0] s_emb_tdata = '0;
  logic s_vid_tvalid = 1'b0, s_vid_tready;
  logic [DW-1:0] s_vid_tdata = '0;
  logic s_vid_tuser = 1'b0, s_vid_tlast = 1'b0;
  logic m_axis_tvalid, m_axis_tready = 1'b1;
  logic [DW-1:0] m_axis_tdata;
  logic [95:0] m_axis_tuser;
  logic m_axis_tlast;
  logic [31:0] frame_cnt;
  logic frame_done, len_err, sof_err;

  emb_frame_scheduler #(
    .DATA_W(DW), .H_SIZE(H), .V_SIZE(V),
    .FRONT_LINE(FL), .TAIL_LINE(TL),
    .EMB_TYPE(ET), .RAW12_TYPE(VT)
  ) dut (
    .aclk(aclk), .areset(areset), .enable(enable),
    .s_emb_tvalid(s_emb_tvalid), .s_emb_tready(s_emb_tready),
    .s_emb_tdata(s_emb_tdata),
    .s_vid_tvalid(s_vid_tvalid), .s_vid_tready(s_vid_tready),
    .s_vid_tdata(s_vid_tdata), .s_vid_tuser(s_vid_tuser),
    .s_vid_tlast(s_vid_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast),
    .frame_cnt(frame_cnt), .frame_done(frame_done),
    .len_err(len_err), .sof_err(sof_err)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic u;
    logic l;
  } vin_t;

  typedef struct packed {
    logic [DW-1:0] d;
    logic l;
    logic [95:0] u;
  } out_t;

  logic [DW-1:0] emb_q[$];
  vin_t vid_q[$];
  out_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int out_beats = 0;
  int done_seen = 0;
  int vld_pct = 100;
  int rdy_pct = 100;
  int ebase = 32'h1000;
  int vbase = 32'h4000;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [95:0] mk_user(input logic [5:0] t,
                                          input logic s);
    return {32'd0, 16'(H), 41'd0, t, s};
  endfunction

  task automatic push_exp(input logic [DW-1:0] d, input logic l,
                          input logic [95:0] u);
    out_t o;
    o.d = d;
    o.l = l;
    o.u = u;
    exp_q.push_back(o);
  endtask

  task automatic push_vid(input logic [DW-1:0] d, input logic u,
                          input logic l);
    vin_t v;
    v.d = d;
    v.u = u;
    v.l = l;
    vid_q.push_back(v);
  endtask

  task automatic build_frame(input int junk, input int bad_line,
                             input int bad_len, input bit stray,
                             input bit exp_en);
    for (int j = 0; j < junk; j++)
      push_vid(16'hBAD0 + 16'(j), 1'b0, j == 1);
    for (int l = 0; l < FL; l++)
      for (int c = 0; c < H; c++) begin
        emb_q.push_back(16'(ebase));
        if (exp_en)
          push_exp(16'(ebase), c == H - 1,
                   mk_user(ET, l == 0 && c == 0));
        ebase++;
      end
    for (int v = 0; v < V; v++) begin
      int len;
      len = (v == bad_line) ? bad_len : H;
      for (int c = 0; c < len; c++)
        push_vid(16'(vbase + c),
                 (v == 0 && c == 0) || (stray && v == 3 && c == 2),
                 c == len - 1);
      if (exp_en)
        for (int c = 0; c < H; c++)
          push_exp(c < len ? 16'(vbase + c) : 16'd0, c == H - 1,
                   mk_user(VT, 1'b0));
      vbase += 16;
    end
    for (int l = 0; l < TL; l++)
      for (int c = 0; c < H; c++) begin
        emb_q.push_back(16'(ebase));
        if (exp_en)
          push_exp(16'(ebase), c == H - 1, mk_user(ET, 1'b0));
        ebase++;
      end
  endtask

  task automatic drive();
    s_emb_tvalid = emb_q.size() > 0 && int'($urandom_range(99)) < vld_pct;
    s_emb_tdata = emb_q.size() > 0 ? emb_q[0] : '0;
    s_vid_tvalid = vid_q.size() > 0 && int'($urandom_range(99)) < vld_pct;
    s_vid_tdata = vid_q.size() > 0 ? vid_q[0].d : '0;
    s_vid_tuser = vid_q.size() > 0 ? vid_q[0].u : 1'b0;
    s_vid_tlast = vid_q.size() > 0 ? vid_q[0].l : 1'b0;
    m_axis_tready = int'($urandom_range(99)) < rdy_pct;
  endtask

  task automatic step();
    bit efire, vfire;
    out_t e;
    @(negedge aclk);
    if (m_axis_tvalid && m_axis_tready) begin
      out_beats++;
      if (exp_q.size() == 0) begin
        check("extra_beat", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("tdata", m_axis_tdata, e.d);
        check("tlast", m_axis_tlast, e.l);
        check("tuser", m_axis_tuser, e.u);
      end
    end
    if (frame_done) done_seen++;
    efire = s_emb_tvalid && s_emb_tready;
    vfire = s_vid_tvalid && s_vid_tready;
    @(posedge aclk);
    #1;
    if (efire) void'(emb_q.pop_front());
    if (vfire) void'(vid_q.pop_front());
    drive();
  endtask

  task automatic wait_done(input string tag, input int frames);
    int n = 0;
    while ((exp_q.size() != 0 || done_seen < frames) && n < LIM) begin
      step();
      n++;
    end
    check(tag, n < LIM, 1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tvalid"}, m_axis_tvalid, 0);
    check({tag, "_tdata"}, m_axis_tdata, 0);
    check({tag, "_tuser"}, m_axis_tuser, 0);
    check({tag, "_tlast"}, m_axis_tlast, 0);
    check({tag, "_emb_rdy"}, s_emb_tready, 0);
    check({tag, "_vid_rdy"}, s_vid_tready, 0);
    check({tag, "_fcnt"}, frame_cnt, 0);
    check({tag, "_fdone"}, frame_done, 0);
    check({tag, "_len"}, len_err, 0);
    check({tag, "_sof"}, sof_err, 0);
  endtask

  task automatic clear_q();
    emb_q.delete();
    vid_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset(input string tag);
    areset = 1'b1;
    enable = 1'b0;
    clear_q();
    drive();
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    done_seen = 0;
    @(negedge aclk);
    check_idle(tag);
    @(posedge aclk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    do_reset("rst0");

    // clean frame
    build_frame(0, -1, 0, 1'b0, 1'b1);
    enable = 1'b1;
    out_beats = 0;
    drive();
    wait_done("p1_timeout", 1);
    check("p1_beats", out_beats, 56);
    check("p1_fcnt", frame_cnt, 1);
    check("p1_done", done_seen, 1);
    check("p1_len", len_err, 0);
    check("p1_sof", sof_err, 0);

    // junk before start-of-frame
    build_frame(3, -1, 0, 1'b0, 1'b1);
    out_beats = 0;
    wait_done("p2_timeout", 2);
    check("p2_beats", out_beats, 56);
    check("p2_vid_left", vid_q.size(), 0);
    check("p2_fcnt", frame_cnt, 2);

    // short video line 1 -> padded
    build_frame(0, 1, 5, 1'b0, 1'b1);
    out_beats = 0;
    wait_done("p3_timeout", 3);
    check("p3_beats", out_beats, 56);
    check("p3_len", len_err, 1);
    check("p3_sof", sof_err, 0);
    check("p3_fcnt", frame_cnt, 3);

    // long video line 2 -> dropped tail, stray tuser
    do_reset("rst4");
    build_frame(0, 2, 11, 1'b1, 1'b1);
    enable = 1'b1;
    out_beats = 0;
    drive();
    wait_done("p4_timeout", 1);
    check("p4_beats", out_beats, 56);
    check("p4_len", len_err, 1);
    check("p4_sof", sof_err, 1);
    check("p4_vid_left", vid_q.size(), 0);
    check("p4_fcnt", frame_cnt, 1);

    // random backpressure, three frames
    do_reset("rst5");
    vld_pct = 70;
    rdy_pct = 60;
    for (int f = 0; f < 3; f++) build_frame(f, -1, 0, 1'b0, 1'b1);
    enable = 1'b1;
    out_beats = 0;
    drive();
    wait_done("p5_timeout", 3);
    check("p5_beats", out_beats, 168);
    check("p5_fcnt", frame_cnt, 3);
    check("p5_done", done_seen, 3);
    check("p5_len", len_err, 0);
    vld_pct = 100;
    rdy_pct = 100;

    // reset in the middle of video line 3
    do_reset("rst6");
    build_frame(0, -1, 0, 1'b0, 1'b1);
    enable = 1'b1;
    out_beats = 0;
    drive();
    n = 0;
    while (out_beats < 43 && n < LIM) begin
      step();
      n++;
    end
    check("p6_reach", out_beats >= 43, 1);
    areset = 1'b1;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    enable = 1'b0;
    clear_q();
    drive();
    @(negedge aclk);
    check_idle("p6_rst");
    @(posedge aclk);
    #1;

    // restart, drop enable during frame 2
    done_seen = 0;
    build_frame(0, -1, 0, 1'b0, 1'b1);
    build_frame(0, -1, 0, 1'b0, 1'b1);
    build_frame(2, -1, 0, 1'b0, 1'b0);
    enable = 1'b1;
    out_beats = 0;
    drive();
    n = 0;
    while (out_beats < 66 && n < LIM) begin
      step();
      n++;
    end
    check("p6_f2", out_beats >= 66, 1);
    enable = 1'b0;
    wait_done("p6_timeout", 2);
    repeat (10) step();
    check("p6_beats", out_beats, 112);
    check("p6_fcnt", frame_cnt, 2);
    check("p6_done", done_seen, 2);
    check("p6_vid_left", vid_q.size(), 2 + V * H);
    @(negedge aclk);
    check("p6_idle_vrdy", s_vid_tready, 0);
    check("p6_idle_tvalid", m_axis_tvalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
